ram_line_reader: RTL and testbench

- Read-side sequencer for the single-port-write line buffer RAM used in the binarised-image path.
- On a start pulse it walks a programmed address range, drives the RAM's combinational read address, registers the returned data, and streams it out over a valid/ready interface with a last marker.
- Feeds the downstream projection and segmentation logic that consumes stored binary rows.

---
 rtl/ram_reader_pkg.sv | 7 +
 rtl/rd_out_stage.sv | 43 ++++
 rtl/ram_line_reader.sv | 88 ++++++++
 tb/tb_ram_line_reader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared scan-state encoding and end-index clamp for ram_line_reader.
package ram_reader_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;
   function automatic int unsigned clamp_end(input int unsigned e, input int unsigned depth);
      return (e > depth - 1) ? depth - 1 : e;
   endfunction
endpackage

// File: rtl/rd_out_stage.sv
// rd_out_stage: single-entry valid/ready output register carrying data, index and last.
module rd_out_stage #(
   parameter int WIDTH  = 1,
   parameter int DEPBIT = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              ready_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic [DEPBIT-1:0] index_i,
   input  logic              last_i,
   output logic              load_o,
   output logic              valid_o,
   output logic [WIDTH-1:0]  data_o,
   output logic [DEPBIT-1:0] index_o,
   output logic              last_o
);
   logic              valid_q;
   logic [WIDTH-1:0]  data_q;
   logic [DEPBIT-1:0] index_q;
   logic              last_q;
   assign load_o  = en_i && (!valid_q || ready_i);
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign index_o = index_q;
   assign last_o  = last_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
      end else if (load_o) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         index_q <= index_i;
         last_q  <= last_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/ram_line_reader.sv
// ram_line_reader: walks a RAM address range and streams words out over valid/ready with last.
// Optional RAM_READER_ONES_CNT_EN adds ones_cnt, counting accepted non-zero beats per scan.
module ram_line_reader
   import ram_reader_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int DEPTH  = 800,
   parameter int DEPBIT = 10
) (
`ifdef RAM_READER_ONES_CNT_EN
   output logic [DEPBIT:0]   ones_cnt,
`endif
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DEPBIT-1:0] rd_start,
   input  logic [DEPBIT-1:0] rd_end,
   output logic              busy,
   output logic              done,
   output logic [DEPBIT-1:0] raddr,
   input  logic [WIDTH-1:0]  ram_dq,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [DEPBIT-1:0] out_index,
   output logic              out_last
);
   state_e            state_q, state_d;
   logic [DEPBIT-1:0] cur_q, cur_d, end_q, end_d, end_eff;
   logic              ld;
   assign end_eff = DEPBIT'(clamp_end(32'(rd_end), DEPTH));
   assign raddr   = cur_q;
   assign busy    = (state_q == READ) || (state_q == DRAIN);
   assign done    = state_q == DONE;
   // An empty range parks in DRAIN with nothing valid, giving one busy cycle before done.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      end_d   = end_q;
      case (state_q)
         IDLE: if (start) begin
            cur_d   = rd_start;
            end_d   = end_eff;
            state_d = (rd_start > end_eff) ? DRAIN : READ;
         end
         READ: if (ld) begin
            state_d = (cur_q == end_q) ? DRAIN : READ;
            cur_d   = (cur_q == end_q) ? cur_q : cur_q + DEPBIT'(1);
         end
         DRAIN: state_d = (!out_valid || out_ready) ? DONE : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         end_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
      end
   end
   rd_out_stage #(.WIDTH(WIDTH), .DEPBIT(DEPBIT)) u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (state_q == READ),
      .ready_i (out_ready),
      .data_i  (ram_dq),
      .index_i (cur_q),
      .last_i  (cur_q == end_q),
      .load_o  (ld),
      .valid_o (out_valid),
      .data_o  (out_data),
      .index_o (out_index),
      .last_o  (out_last)
   );
`ifdef RAM_READER_ONES_CNT_EN
   logic [DEPBIT:0] ones_q;
   assign ones_cnt = ones_q;
   always_ff @(posedge clk) begin
      if (!rst_n) ones_q <= '0;
      else if (state_q == IDLE && start) ones_q <= '0;
      else if (out_valid && out_ready && |out_data) ones_q <= ones_q + (DEPBIT+1)'(1);
   end
`endif
endmodule

// File: tb/tb_ram_line_reader.sv
// tb_ram_line_reader: directed scans over a modelled RAM with hand-computed beat sequences.
module tb_ram_line_reader;
   localparam int WIDTH  = 1;
   localparam int DEPTH  = 800;
   localparam int DEPBIT = 10;
   logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic [DEPBIT-1:0] rd_start = '0, rd_end = '0;
   logic              busy, done, out_valid, out_last;
   logic [DEPBIT-1:0] raddr, out_index;
   logic [WIDTH-1:0]  out_data, ram_dq;
`ifdef RAM_READER_ONES_CNT_EN
   logic [DEPBIT:0]   ones_cnt;
`endif
   logic [WIDTH-1:0]  mem [DEPTH];
   int                checks = 0, errors = 0;
   always #5 clk = ~clk;
   assign ram_dq = mem[raddr];
   ram_line_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPBIT(DEPBIT)) dut (
`ifdef RAM_READER_ONES_CNT_EN
      .ones_cnt  (ones_cnt),
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rd_start  (rd_start),
      .rd_end    (rd_end),
      .busy      (busy),
      .done      (done),
      .raddr     (raddr),
      .ram_dq    (ram_dq),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_last"}, 32'(out_last), 0);
      chk({tag, "_data"}, 32'(out_data), 0);
      chk({tag, "_index"}, 32'(out_index), 0);
      chk({tag, "_raddr"}, 32'(raddr), 0);
   endtask
   // mode bit0: ready pattern 1,0,0 repeating; bit1: start pulses during READ and in the DONE cycle
   task automatic scan(input int s, input int e, input int mode, input logic [31:0] bits,
                       input int nexp, input int ones);
      int                eff;
      int                idx;
      int                n;
      int                hs;
      bit                fin;
      logic [31:0]       seq;
      logic              pv, pr;
      logic [WIDTH-1:0]  pd;
      logic [DEPBIT-1:0] pi, pa;
      eff = (e > DEPTH - 1) ? DEPTH - 1 : e;
      idx = s; n = 0; hs = -10; fin = 0; seq = 0; pv = 0; pr = 0; pd = '0; pi = '0; pa = '0;
      rd_start = DEPBIT'(s);
      rd_end   = DEPBIT'(e);
      start    = 1'b1;
      step();
`ifdef RAM_READER_ONES_CNT_EN
      chk("ones_clr", 32'(ones_cnt), 0);
`endif
      for (int c = 0; c < 200 && !fin; c++) begin
         start     = 1'b0;
         out_ready = mode[0] ? (c % 3 == 0) : 1'b1;
         if (mode[1] && c == 1) begin
            rd_start = '0;
            rd_end   = '0;
            start    = 1'b1;
         end
         if (c == 0) chk("lat0_valid", 32'(out_valid), 0);
         if (c == 1 && nexp > 0) chk("lat1_valid", 32'(out_valid), 1);
         if (pv && !pr) begin
            chk("stall_data", 32'(out_data), 32'(pd));
            chk("stall_index", 32'(out_index), 32'(pi));
            chk("stall_raddr", 32'(raddr), 32'(pa));
         end
         if (out_valid) begin
            chk("beat_index", 32'(out_index), idx);
            chk("beat_data", 32'(out_data), 32'(mem[idx]));
            chk("beat_last", 32'(out_last), 32'(idx == eff));
         end
         if (!done) chk("busy_run", 32'(busy), 1);
         if (out_valid && out_ready) begin
            seq = {seq[30:0], out_data};
            idx++;
            n++;
            hs = c;
         end
         if (done) begin
            chk("done_lag", c, (n == 0) ? 1 : hs + 1);
            chk("busy_done", 32'(busy), 0);
            chk("beat_count", n, nexp);
            chk("beat_seq", seq, bits);
`ifdef RAM_READER_ONES_CNT_EN
            chk("ones_done", 32'(ones_cnt), ones);
`endif
            if (mode[1]) begin
               rd_start = '0;
               rd_end   = '0;
               start    = 1'b1;
            end
            fin = 1;
         end
         pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pa = raddr;
         step();
      end
      start = 1'b0;
      if (!fin) chk("done_timeout", 0, 1);
      chk("after_done_busy", 32'(busy), 0);
      chk("after_done_done", 32'(done), 0);
      if (mode[1]) begin
         step();
         chk("ign_start_busy", 32'(busy), 0);
         chk("ign_start_valid", 32'(out_valid), 0);
      end
   endtask
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem[0] = 1; mem[2] = 1; mem[5] = 1; mem[6] = 1; mem[7] = 1;
      mem[797] = 1; mem[799] = 1;
      step();
      step();
      chk_idle_zero("reset");
      rst_n = 1'b1;
      step();
      scan(2, 6, 0, 32'h13, 5, 3);
      step();
      scan(2, 6, 1, 32'h13, 5, 3);
      step();
      scan(5, 3, 0, 32'h0, 0, 0);
      step();
      scan(797, 1000, 2, 32'h5, 3, 2);
      step();
      rd_start = 10'd2;
      rd_end   = 10'd6;
      start    = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("pre_abort_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      step();
      chk_idle_zero("abort");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("abort_no_done", 32'(done), 0);
         chk("abort_no_valid", 32'(out_valid), 0);
      end
      scan(0, 3, 0, 32'hA, 4, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
